// File: rtl/multicycle_data_path_pkg.sv
// Shared encodings for the multicycle datapath: word width, ALU operation codes,
// SrcB select codes and the ALU evaluation helper.
package multicycle_data_path_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluOp_e;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_X4 = 2'b11
  } srcBSel_e;

  // Unlisted operation codes deliberately produce zero rather than a partial decode.
  function automatic word_t aluCompute(input logic [2:0] op, input word_t a, input word_t b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mdp_reg_file.sv
// 32x32 register file: two combinational operand reads, one debug read, one synchronous
// write. Register 0 is never written, so it always reads zero.
module mdp_reg_file
  import multicycle_data_path_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] readAddr1,
  input  logic [4:0] readAddr2,
  input  logic [4:0] debugAddr,
  input  logic [4:0] writeAddr,
  input  logic       writeEn,
  input  word_t      writeData,
  output word_t      readData1,
  output word_t      readData2,
  output word_t      debugData
);

  word_t regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn && (writeAddr != 5'd0)) begin
      regs[writeAddr] <= writeData;
    end
  end

  // Reads see the pre-write contents in the cycle of a write; no bypass.
  assign readData1 = regs[readAddr1];
  assign readData2 = regs[readAddr2];
  assign debugData = regs[debugAddr];

endmodule

// File: rtl/multicycle_data_path.sv
// Multicycle MIPS datapath (PC, unified memory, IR/MDR/A/B/ALUOut, regfile, ALU) driven by an
// external controller. Define ZERO_FLAG_EN to add the `zero` output (ALUResult == 0).
module multicycle_data_path
  import multicycle_data_path_pkg::*;
#(
  parameter int    MEM_WORDS     = 64,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCEn,
  input  logic        IorD,
  input  logic        Memwrite,
  input  logic        IRWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        ALUsrcA,
  input  logic [1:0]  ALUsrcB,
  input  logic [2:0]  ALUControl,
  input  logic        PCsrc,
  input  logic [4:0]  addressTest,
  output logic [31:0] outputTest
`ifdef ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);

  // MEM_WORDS is expected to be a power of two: upper address bits are simply dropped.
  localparam int AW = $clog2(MEM_WORDS);

  word_t pcReg, irReg, mdrReg, aReg, bReg, aluOutReg;
  word_t pcNext, memRdData, signImm, srcA, srcB, aluResult;
  word_t rfRd1, rfRd2, rfWd;
  logic [4:0]    rfWa;
  logic [AW-1:0] memIdx;
  logic          unusedOpcode;

  word_t mem [MEM_WORDS];

  assign memIdx    = IorD ? aluOutReg[AW+1:2] : pcReg[AW+1:2];
  assign memRdData = mem[memIdx];

  assign signImm = {{16{irReg[15]}}, irReg[15:0]};
  assign srcA    = ALUsrcA ? aReg : pcReg;

  always_comb begin
    srcB = bReg;
    case (ALUsrcB)
      SRCB_FOUR:   srcB = 32'd4;
      SRCB_IMM:    srcB = signImm;
      SRCB_IMM_X4: srcB = {signImm[29:0], 2'b00};
      default:     srcB = bReg;
    endcase
  end

  assign aluResult = aluCompute(ALUControl, srcA, srcB);
  assign pcNext    = PCsrc ? aluOutReg : aluResult;

  assign rfWa = RegDst ? irReg[15:11] : irReg[20:16];
  assign rfWd = MemtoReg ? mdrReg : aluOutReg;

  // Opcode bits belong to the external controller; the datapath never looks at them.
  assign unusedOpcode = ^irReg[31:26];

  mdp_reg_file uRegFile (
    .clk       (clk),
    .rst       (rst),
    .readAddr1 (irReg[25:21]),
    .readAddr2 (irReg[20:16]),
    .debugAddr (addressTest),
    .writeAddr (rfWa),
    .writeEn   (RegWrite),
    .writeData (rfWd),
    .readData1 (rfRd1),
    .readData2 (rfRd2),
    .debugData (outputTest)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcReg     <= '0;
      irReg     <= '0;
      mdrReg    <= '0;
      aReg      <= '0;
      bReg      <= '0;
      aluOutReg <= '0;
    end else begin
      mdrReg    <= memRdData;
      aReg      <= rfRd1;
      bReg      <= rfRd2;
      aluOutReg <= aluResult;
      if (IRWrite) irReg <= memRdData;
      if (PCEn)    pcReg <= pcNext;
    end
  end

  // Memory keeps its contents across reset. A same-edge IR load sees the old word.
  always_ff @(posedge clk) begin
    if (Memwrite) mem[memIdx] <= bReg;
  end

`ifdef ZERO_FLAG_EN
  assign zero = (aluResult == '0);
`endif

endmodule

// File: tb/tb_multicycle_data_path.sv
// Randomized and directed bench for multicycle_data_path against an architectural reference model.
module tb_multicycle_data_path;

  localparam int MEMW = 64;

  typedef struct packed {
    logic       pcEn;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       srcA;
    logic [1:0] srcB;
    logic [2:0] op;
    logic       pcSrc;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc;
  logic [1:0]  ALUsrcB;
  logic [2:0]  ALUControl;
  logic [4:0]  addressTest;
  logic [31:0] outputTest;
`ifdef ZERO_FLAG_EN
  logic        zero;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] mPc, mIr, mMdr, mA, mB, mAluOut;
  logic [31:0] mRf  [32];
  logic [31:0] mMem [MEMW];

  logic [2:0]  aluOps [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  logic [31:0] aluExp [5] = '{32'd12, 32'hFFFFFFFE, 32'd5, 32'd7, 32'd1};

  multicycle_data_path #(.MEM_WORDS(MEMW)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCEn        (PCEn),
    .IorD        (IorD),
    .Memwrite    (Memwrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUsrcA     (ALUsrcA),
    .ALUsrcB     (ALUsrcB),
    .ALUControl  (ALUControl),
    .PCsrc       (PCsrc),
    .addressTest (addressTest),
    .outputTest  (outputTest)
`ifdef ZERO_FLAG_EN
    ,
    .zero        (zero)
`endif
  );

  always #50 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (op)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] modelResult(input ctrl_t c);
    int imm;
    logic [31:0] a, b;
    imm = int'($signed(mIr[15:0]));
    a   = c.srcA ? mA : mPc;
    case (c.srcB)
      2'b00:   b = mB;
      2'b01:   b = 32'd4;
      2'b10:   b = imm;
      default: b = imm * 4;
    endcase
    return refAlu(c.op, a, b);
  endfunction

  task automatic modelReset();
    mPc = 0; mIr = 0; mMdr = 0; mA = 0; mB = 0; mAluOut = 0;
    for (int i = 0; i < 32; i++) mRf[i] = 0;
  endtask

  // One clock edge of the architecture: everything computed from pre-edge state first.
  task automatic modelClock(input ctrl_t c);
    logic [31:0] res, rd, nA, nB, wd, addr;
    int idx, wa;
    res  = modelResult(c);
    addr = c.iorD ? mAluOut : mPc;
    idx  = int'(addr >> 2) % MEMW;
    rd   = mMem[idx];
    wa   = c.regDst ? int'(mIr[15:11]) : int'(mIr[20:16]);
    wd   = c.memToReg ? mMdr : mAluOut;
    nA   = mRf[mIr[25:21]];
    nB   = mRf[mIr[20:16]];
    if (c.memWrite) mMem[idx] = mB;
    if (c.regWrite && wa != 0) mRf[wa] = wd;
    if (c.pcEn) mPc = c.pcSrc ? mAluOut : res;
    if (c.irWrite) mIr = rd;
    mAluOut = res;
    mMdr    = rd;
    mA      = nA;
    mB      = nB;
  endtask

  task automatic step(input ctrl_t c, input string name);
    int dbg;
    {PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, ALUsrcB, ALUControl, PCsrc} = c;
    #1;
`ifdef ZERO_FLAG_EN
    checkVal({name, ".zero"}, {31'd0, zero}, {31'd0, (modelResult(c) == 32'd0)});
`endif
    @(posedge clk);
    modelClock(c);
    #1;
    checkVal({name, ".pc"},     dut.pcReg,     mPc);
    checkVal({name, ".ir"},     dut.irReg,     mIr);
    checkVal({name, ".aluOut"}, dut.aluOutReg, mAluOut);
    checkVal({name, ".mdr"},    dut.mdrReg,    mMdr);
    checkVal({name, ".a"},      dut.aReg,      mA);
    checkVal({name, ".b"},      dut.bReg,      mB);
    dbg = $urandom_range(31);
    addressTest = 5'(dbg);
    #1;
    checkVal({name, ".rf"}, outputTest, mRf[dbg]);
    $display("step %-8s ctrl=%04h pc=%08h ir=%08h rf[%0d]=%08h", name, c, dut.pcReg, dut.irReg, dbg, outputTest);
  endtask

  task automatic expectReg(input string tag, input int r, input logic [31:0] v);
    addressTest = 5'(r);
    #1;
    checkVal(tag, outputTest, v);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    dut.mem[idx] = v;
    mMem[idx]    = v;
  endtask

  function automatic ctrl_t cFetch();
    ctrl_t c;
    c = '0; c.pcEn = 1'b1; c.irWrite = 1'b1; c.srcB = 2'b01; c.op = 3'b010;
    return c;
  endfunction

  function automatic ctrl_t cExec(input logic [2:0] op, input logic [1:0] srcB);
    ctrl_t c;
    c = '0; c.srcA = 1'b1; c.srcB = srcB; c.op = op;
    return c;
  endfunction

  function automatic ctrl_t cMem(input logic wr);
    ctrl_t c;
    c = cExec(3'b010, 2'b10); c.iorD = 1'b1; c.memWrite = wr;
    return c;
  endfunction

  function automatic ctrl_t cWb(input logic regDst, input logic memToReg);
    ctrl_t c;
    c = '0; c.regWrite = 1'b1; c.regDst = regDst; c.memToReg = memToReg;
    return c;
  endfunction

  task automatic runLw();
    step(cFetch(), "fetch");
    step('0, "decode");
    step(cExec(3'b010, 2'b10), "exec");
    step(cMem(1'b0), "mem");
    step(cWb(1'b0, 1'b1), "wb");
  endtask

  initial begin
    ctrl_t c;
    {PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, ALUsrcB, ALUControl, PCsrc} = '0;
    addressTest = '0;
    for (int i = 0; i < MEMW; i++) preload(i, 32'd0);
    preload(0, 32'h8C090020);   // lw  $9, 32($0)
    preload(1, 32'h8C0A0024);   // lw  $10, 36($0)
    preload(2, 32'h8C0B0028);   // lw  $11, 40($0)
    preload(3, 32'h8C0C002C);   // lw  $12, 44($0)
    preload(4, 32'h016C6820);   // add $13, $11, $12
    preload(5, 32'hAC0A0010);   // sw  $10, 16($0)
    preload(6, 32'h216FFFFC);   // addi $15, $11, -4
    preload(7, 32'h3400FFFF);   // rt = $0, imm 0xFFFF
    preload(8, 32'h000000AB);
    preload(9, 32'h00001234);
    preload(10, 32'd5);
    preload(11, 32'd7);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset.pc", dut.pcReg, 32'd0);
    rst = 1'b0;

    step(cFetch(), "fetch0");
    checkVal("fetch0.irConst", dut.irReg, 32'h8C090020);
    checkVal("fetch0.pcConst", dut.pcReg, 32'd4);
    step('0, "decode");
    step(cExec(3'b010, 2'b10), "exec");
    step(cMem(1'b0), "mem");
    step(cWb(1'b0, 1'b1), "wb");
    expectReg("lw9.rf", 9, 32'h000000AB);
    checkVal("lw9.pc", dut.pcReg, 32'd4);

    runLw();
    runLw();
    runLw();
    expectReg("lw10.rf", 10, 32'h00001234);
    expectReg("lw12.rf", 12, 32'd7);

    step(cFetch(), "fetchR");
    step('0, "decode");
    for (int k = 0; k < 5; k++) begin
      step(cExec(aluOps[k], 2'b00), "aluExec");
      step(cWb(1'b1, 1'b0), "aluWb");
      expectReg($sformatf("alu.op%0d", aluOps[k]), 13, aluExp[k]);
    end

    step(cFetch(), "fetchSw");
    step('0, "decode");
    step(cExec(3'b010, 2'b10), "exec");
    step(cMem(1'b1), "swMem");
    checkVal("sw.mem4", dut.mem[4], 32'h00001234);

    step(cFetch(), "fetchAddi");
    step('0, "decode");
    step(cExec(3'b010, 2'b10), "exec");
    step(cWb(1'b0, 1'b0), "wb");
    expectReg("negImm.rf", 15, 32'd1);
    step(cExec(3'b010, 2'b11), "execX4");
    step(cWb(1'b0, 1'b0), "wb");
    expectReg("negImmX4.rf", 15, 32'hFFFFFFF5);

    step(cFetch(), "fetchR0");
    step('0, "decode");
    step(cExec(3'b001, 2'b10), "exec");
    checkVal("r0.aluOut", dut.aluOutReg, 32'hFFFFFFFF);
    step(cWb(1'b0, 1'b0), "wbR0");
    expectReg("r0.rf", 0, 32'd0);

    // IR load and store hit the same word on one edge.
    c = '0; c.irWrite = 1'b1; c.memWrite = 1'b1;
    step(c, "collide");
    checkVal("collide.ir", dut.irReg, 32'h000000AB);
    checkVal("collide.mem8", dut.mem[8], 32'd0);

    repeat (400) begin
      c = 14'($urandom);
      step(c, "rand");
    end

    rst = 1'b1;
    #1;
    checkVal("midReset.pc",     dut.pcReg,     32'd0);
    checkVal("midReset.ir",     dut.irReg,     32'd0);
    checkVal("midReset.aluOut", dut.aluOutReg, 32'd0);
    for (int i = 0; i < 32; i++) begin
      addressTest = 5'(i);
      #1;
      checkVal($sformatf("midReset.rf%0d", i), outputTest, 32'd0);
    end
    modelReset();
    {PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, ALUsrcB, ALUControl, PCsrc} = '0;
    rst = 1'b0;

    step(cFetch(), "refetch");
    checkVal("refetch.memKept", dut.irReg, mMem[0]);
    repeat (40) begin
      c = 14'($urandom);
      step(c, "rand2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
